// File: rtl/stage_mem_ctrl_if.sv
// MMU request/ack bus between the memory stage and the MMU.
// master drives the request side, slave returns data/ack/fault.
interface stage_mem_ctrl_if #(
    parameter int EXC_W = 5
);
    logic             mmu_req;
    logic             mmu_we;
    logic [31:0]      mmu_addr;
    logic [3:0]       mmu_be;
    logic [31:0]      mmu_wdata;
    logic [31:0]      mmu_rdata;
    logic             mmu_ack;
    logic             mmu_exc_valid;
    logic [EXC_W-1:0] mmu_exc_code;

    modport master (
        output mmu_req, mmu_we, mmu_addr, mmu_be, mmu_wdata,
        input  mmu_rdata, mmu_ack, mmu_exc_valid, mmu_exc_code
    );

    modport slave (
        input  mmu_req, mmu_we, mmu_addr, mmu_be, mmu_wdata,
        output mmu_rdata, mmu_ack, mmu_exc_valid, mmu_exc_code
    );
endinterface

// File: rtl/stage_mem_ctrl.sv
// Memory stage: sub-word loads/stores over the MMU handshake,
// precise exceptions and interrupt prioritisation.
module stage_mem_ctrl #(
    parameter int NR_INT     = 8,
    parameter int REG_ADDR_W = 5,
    parameter int EXC_W      = 5,
    parameter int TIMEOUT    = 255,
    parameter int EC_INT     = 0,
    parameter int EC_ADEL    = 4,
    parameter int EC_ADES    = 5,
    parameter int EC_DBE     = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [3:0]            in_op,
    input  logic [31:0]           in_addr,
    input  logic [31:0]           in_wdata,
    input  logic [31:0]           in_alu_result,
    input  logic [REG_ADDR_W-1:0] in_wb_addr,
    input  logic                  in_exc_valid,
    input  logic [EXC_W-1:0]      in_exc_code,
    input  logic [31:0]           in_badvaddr,
    input  logic [NR_INT-1:0]     int_req,
    input  logic [NR_INT-1:0]     int_mask,
    input  logic                  int_enable,
    output logic [NR_INT-1:0]     int_ack,
    output logic                  stall,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_reg_addr,
    output logic [31:0]           wb_reg_data,
    output logic                  exc_valid,
    output logic [EXC_W-1:0]      exc_code,
    output logic [31:0]           exc_badvaddr,
    output logic [NR_INT-1:0]     exc_ip,
    stage_mem_ctrl_if.master      mmu
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [3:0]            op_q;
    logic [31:0]           addr_q;
    logic [REG_ADDR_W-1:0] wb_q;

    logic                  is_ld;
    logic                  is_st;
    logic [1:0]            sz;
    logic                  misal;
    logic [3:0]            be;
    logic [31:0]           wd;
    logic [NR_INT-1:0]     pend;
    logic [NR_INT-1:0]     int_hot;
    logic                  take_int;
    logic [31:0]           lane;
    logic [31:0]           ld_data;
    logic                  ld_q;

    // sz: 0 byte, 1 half, 2 word
    always_comb begin
        is_ld = 1'b0;
        is_st = 1'b0;
        sz    = 2'd0;
        case (in_op)
            OP_LB, OP_LBU: begin is_ld = 1'b1; sz = 2'd0; end
            OP_LH, OP_LHU: begin is_ld = 1'b1; sz = 2'd1; end
            OP_LW:         begin is_ld = 1'b1; sz = 2'd2; end
            OP_SB:         begin is_st = 1'b1; sz = 2'd0; end
            OP_SH:         begin is_st = 1'b1; sz = 2'd1; end
            OP_SW:         begin is_st = 1'b1; sz = 2'd2; end
            default: ;
        endcase
        misal = (sz == 2'd1 && in_addr[0]) ||
                (sz == 2'd2 && in_addr[1:0] != 2'b00);
        case (sz)
            2'd0:    be = 4'b0001 << in_addr[1:0];
            2'd1:    be = in_addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        case (sz)
            2'd0:    wd = {4{in_wdata[7:0]}};
            2'd1:    wd = {2{in_wdata[15:0]}};
            default: wd = in_wdata;
        endcase
        pend     = int_req & int_mask;
        int_hot  = pend & (~pend + 1'b1);
        take_int = int_enable && (pend != '0);
    end

    assign ld_q = (op_q >= OP_LB) && (op_q <= OP_LW);

    always_comb begin
        lane = mmu.mmu_rdata >> {addr_q[1:0], 3'b000};
        case (op_q)
            OP_LB:   ld_data = {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  ld_data = {24'd0, lane[7:0]};
            OP_LH:   ld_data = {{16{lane[15]}}, lane[15:0]};
            OP_LHU:  ld_data = {16'd0, lane[15:0]};
            default: ld_data = mmu.mmu_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            op_q          <= '0;
            addr_q        <= '0;
            wb_q          <= '0;
            int_ack       <= '0;
            stall         <= 1'b0;
            wb_valid      <= 1'b0;
            wb_reg_addr   <= '0;
            wb_reg_data   <= '0;
            exc_valid     <= 1'b0;
            exc_code      <= '0;
            exc_badvaddr  <= '0;
            exc_ip        <= '0;
            mmu.mmu_req   <= 1'b0;
            mmu.mmu_we    <= 1'b0;
            mmu.mmu_addr  <= '0;
            mmu.mmu_be    <= '0;
            mmu.mmu_wdata <= '0;
        end else begin
            wb_valid  <= 1'b0;
            exc_valid <= 1'b0;
            int_ack   <= '0;
            unique case (state)
                IDLE: begin
                    if (in_valid && in_exc_valid) begin
                        exc_valid    <= 1'b1;
                        exc_code     <= in_exc_code;
                        exc_badvaddr <= in_badvaddr;
                        exc_ip       <= '0;
                    end else if (take_int) begin
                        exc_valid <= 1'b1;
                        exc_code  <= EXC_W'(EC_INT);
                        exc_ip    <= int_hot;
                        int_ack   <= int_hot;
                    end else if (in_valid && misal) begin
                        exc_valid    <= 1'b1;
                        exc_code     <= is_st ? EXC_W'(EC_ADES)
                                              : EXC_W'(EC_ADEL);
                        exc_badvaddr <= in_addr;
                        exc_ip       <= '0;
                    end else if (in_valid && !(is_ld || is_st)) begin
                        wb_valid    <= 1'b1;
                        wb_reg_addr <= in_wb_addr;
                        wb_reg_data <= in_alu_result;
                    end else if (in_valid) begin
                        op_q          <= in_op;
                        addr_q        <= in_addr;
                        wb_q          <= in_wb_addr;
                        mmu.mmu_req   <= 1'b1;
                        mmu.mmu_we    <= is_st;
                        mmu.mmu_addr  <= {in_addr[31:2], 2'b00};
                        mmu.mmu_be    <= be;
                        mmu.mmu_wdata <= wd;
                        stall         <= 1'b1;
                        cnt           <= CNT_W'(1);
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // counter holds the number of the current WAIT cycle
                    if (mmu.mmu_exc_valid || mmu.mmu_ack ||
                        (TIMEOUT != 0 && cnt == TMO)) begin
                        state       <= IDLE;
                        stall       <= 1'b0;
                        mmu.mmu_req <= 1'b0;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    if (mmu.mmu_exc_valid) begin
                        exc_valid    <= 1'b1;
                        exc_code     <= mmu.mmu_exc_code;
                        exc_badvaddr <= addr_q;
                        exc_ip       <= '0;
                    end else if (mmu.mmu_ack) begin
                        if (ld_q) begin
                            wb_valid    <= 1'b1;
                            wb_reg_addr <= wb_q;
                            wb_reg_data <= ld_data;
                        end
                    end else if (TIMEOUT != 0 && cnt == TMO) begin
                        exc_valid    <= 1'b1;
                        exc_code     <= EXC_W'(EC_DBE);
                        exc_badvaddr <= addr_q;
                        exc_ip       <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stage_mem_ctrl.sv
// Directed bench for stage_mem_ctrl with TIMEOUT=4 and
// hand-computed expectations.
module tb_stage_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_op = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic [31:0] in_alu_result = '0;
    logic [4:0]  in_wb_addr = '0;
    logic        in_exc_valid = 1'b0;
    logic [4:0]  in_exc_code = '0;
    logic [31:0] in_badvaddr = '0;
    logic [7:0]  int_req = '0;
    logic [7:0]  int_mask = '0;
    logic        int_enable = 1'b0;
    logic [7:0]  int_ack;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_reg_addr;
    logic [31:0] wb_reg_data;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_badvaddr;
    logic [7:0]  exc_ip;

    int checks = 0;
    int errors = 0;
    int stalls;

    stage_mem_ctrl_if #(.EXC_W(5)) bus ();

    stage_mem_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_op(in_op),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .in_alu_result(in_alu_result),
        .in_wb_addr(in_wb_addr),
        .in_exc_valid(in_exc_valid),
        .in_exc_code(in_exc_code),
        .in_badvaddr(in_badvaddr),
        .int_req(int_req), .int_mask(int_mask),
        .int_enable(int_enable), .int_ack(int_ack),
        .stall(stall), .wb_valid(wb_valid),
        .wb_reg_addr(wb_reg_addr),
        .wb_reg_data(wb_reg_data),
        .exc_valid(exc_valid), .exc_code(exc_code),
        .exc_badvaddr(exc_badvaddr), .exc_ip(exc_ip),
        .mmu(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op,
                         input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input logic [4:0] wb);
        in_valid   = 1'b1;
        in_op      = op;
        in_addr    = addr;
        in_wdata   = wdata;
        in_wb_addr = wb;
        tick();
        in_valid = 1'b0;
        in_op    = 4'd0;
    endtask

    task automatic ack_after(input int n,
                             input logic [31:0] rdata,
                             output int st);
        st = 0;
        for (int i = 0; i < n; i++) begin
            if (stall) st++;
            if (i == n - 1) begin
                bus.mmu_ack   = 1'b1;
                bus.mmu_rdata = rdata;
            end
            tick();
        end
        bus.mmu_ack = 1'b0;
    endtask

    initial begin
        bus.mmu_rdata     = '0;
        bus.mmu_ack       = 1'b0;
        bus.mmu_exc_valid = 1'b0;
        bus.mmu_exc_code  = '0;
        tick();
        tick();
        chk("rst_stall", stall, 0);
        chk("rst_req", bus.mmu_req, 0);
        chk("rst_wb", wb_valid, 0);
        chk("rst_exc", exc_valid, 0);
        chk("rst_ack", int_ack, 0);
        chk("rst_be", bus.mmu_be, 0);
        rst = 1'b0;
        tick();

        issue(4'd1, 32'h1003, 32'h0, 5'd5);
        chk("lb_req", bus.mmu_req, 1);
        chk("lb_we", bus.mmu_we, 0);
        chk("lb_addr", bus.mmu_addr, 32'h1000);
        chk("lb_be", bus.mmu_be, 4'b1000);
        ack_after(3, 32'h80FFFFFF, stalls);
        chk("lb_stalls", stalls, 3);
        chk("lb_wbv", wb_valid, 1);
        chk("lb_data", wb_reg_data, 32'hFFFFFF80);
        chk("lb_wba", wb_reg_addr, 5);
        chk("lb_req_drop", bus.mmu_req, 0);
        chk("lb_stall_drop", stall, 0);
        tick();
        chk("lb_wb_pulse", wb_valid, 0);

        issue(4'd2, 32'h1003, 32'h0, 5'd6);
        ack_after(3, 32'h80FFFFFF, stalls);
        chk("lbu_data", wb_reg_data, 32'h00000080);

        issue(4'd3, 32'h7002, 32'h0, 5'd8);
        chk("lh_be", bus.mmu_be, 4'b1100);
        ack_after(1, 32'h80011234, stalls);
        chk("lh_data", wb_reg_data, 32'hFFFF8001);

        issue(4'd7, 32'h2002, 32'h1234ABCD, 5'd0);
        chk("sh_addr", bus.mmu_addr, 32'h2000);
        chk("sh_be", bus.mmu_be, 4'b1100);
        chk("sh_wdata", bus.mmu_wdata, 32'hABCDABCD);
        chk("sh_we", bus.mmu_we, 1);
        ack_after(2, 32'h0, stalls);
        chk("sh_nowb", wb_valid, 0);
        chk("sh_req_drop", bus.mmu_req, 0);

        issue(4'd6, 32'h2001, 32'h000000A5, 5'd0);
        chk("sb_be", bus.mmu_be, 4'b0010);
        chk("sb_wdata", bus.mmu_wdata, 32'hA5A5A5A5);
        ack_after(1, 32'h0, stalls);

        issue(4'd5, 32'h3001, 32'h0, 5'd4);
        chk("adel_v", exc_valid, 1);
        chk("adel_code", exc_code, 4);
        chk("adel_bad", exc_badvaddr, 32'h3001);
        chk("adel_req", bus.mmu_req, 0);
        tick();
        chk("adel_pulse", exc_valid, 0);

        issue(4'd8, 32'h3002, 32'h0, 5'd0);
        chk("ades_code", exc_code, 5);
        chk("ades_bad", exc_badvaddr, 32'h3002);

        int_req       = 8'b0110;
        int_mask      = 8'hFF;
        int_enable    = 1'b1;
        in_alu_result = 32'hDEAD;
        issue(4'd0, 32'h0, 32'h0, 5'd3);
        chk("int_v", exc_valid, 1);
        chk("int_code", exc_code, 0);
        chk("int_ip", exc_ip, 8'b0010);
        chk("int_ack", int_ack, 8'b0010);
        chk("int_nowb", wb_valid, 0);
        int_req = 8'b0;
        tick();
        chk("int_ack_pulse", int_ack, 0);
        chk("int_ip_hold", exc_ip, 8'b0010);

        int_req  = 8'b0110;
        int_mask = 8'b0100;
        tick();
        chk("int_masked", int_ack, 8'b0100);

        in_exc_valid = 1'b1;
        in_exc_code  = 5'd12;
        in_badvaddr  = 32'h44;
        issue(4'd0, 32'h0, 32'h0, 5'd3);
        chk("upx_code", exc_code, 12);
        chk("upx_bad", exc_badvaddr, 32'h44);
        chk("upx_ip", exc_ip, 0);
        in_exc_valid = 1'b0;
        int_req      = 8'b0;
        int_enable   = 1'b0;
        tick();

        in_alu_result = 32'h12345678;
        issue(4'd0, 32'h0, 32'h0, 5'd7);
        chk("none_wbv", wb_valid, 1);
        chk("none_data", wb_reg_data, 32'h12345678);
        chk("none_wba", wb_reg_addr, 7);

        issue(4'd5, 32'h4000, 32'h0, 5'd9);
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            if (exc_valid) break;
            if (stall) stalls++;
            tick();
        end
        chk("tmo_stalls", stalls, 4);
        chk("tmo_v", exc_valid, 1);
        chk("tmo_code", exc_code, 7);
        chk("tmo_bad", exc_badvaddr, 32'h4000);
        chk("tmo_req", bus.mmu_req, 0);

        issue(4'd5, 32'h4100, 32'h0, 5'd9);
        ack_after(4, 32'hCAFEF00D, stalls);
        chk("ack_vs_tmo_wb", wb_valid, 1);
        chk("ack_vs_tmo_exc", exc_valid, 0);
        chk("ack_vs_tmo_data", wb_reg_data, 32'hCAFEF00D);

        issue(4'd5, 32'h5000, 32'h0, 5'd9);
        bus.mmu_exc_valid = 1'b1;
        bus.mmu_exc_code  = 5'd2;
        bus.mmu_ack       = 1'b1;
        tick();
        bus.mmu_exc_valid = 1'b0;
        bus.mmu_ack       = 1'b0;
        chk("mmux_v", exc_valid, 1);
        chk("mmux_code", exc_code, 2);
        chk("mmux_bad", exc_badvaddr, 32'h5000);
        chk("mmux_nowb", wb_valid, 0);

        issue(4'd5, 32'h6000, 32'h0, 5'd9);
        chk("rstw_req_pre", bus.mmu_req, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstw_req", bus.mmu_req, 0);
        chk("rstw_stall", stall, 0);
        tick();
        rst = 1'b0;
        tick();
        in_alu_result = 32'h0BADBEEF;
        issue(4'd0, 32'h0, 32'h0, 5'd1);
        chk("rstw_wbv", wb_valid, 1);
        chk("rstw_data", wb_reg_data, 32'h0BADBEEF);
        chk("rstw_noexc", exc_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stage_mem_ctrl.md
Name: stage_mem_ctrl

Overview:
Parametrised memory-stage controller for the pipeline, sitting between EX and WB. Accepts one instruction per cycle while idle and performs sub-word loads/stores (byte/half/word, sign/zero extension, byte enables) over a held request/ack handshake to the MMU. Raises precise exceptions for misalignment, MMU faults and bus timeout. Prioritises and acknowledges a parametrised number of interrupt lines.

Parameters:
NR_INT, 8, number of interrupt request lines
REG_ADDR_W, 5, register address width
EXC_W, 5, exception code width
TIMEOUT, 255, MMU wait cycles before bus error (0 = never time out)
EC_INT, 0, code for interrupt
EC_ADEL, 4, code for misaligned load
EC_ADES, 5, code for misaligned store
EC_DBE, 7, code for bus timeout

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  EX->MEM instruction present
in_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW (others = NONE)
in_addr  in  32  effective address
in_wdata  in  32  store data (low bits significant for SB/SH)
in_alu_result  in  32  writeback data for op NONE
in_wb_addr  in  REG_ADDR_W  destination register (0 = none)
in_exc_valid  in  1  upstream exception present
in_exc_code  in  EXC_W  upstream exception code
in_badvaddr  in  32  upstream bad address
int_req  in  NR_INT  level interrupt requests
int_mask  in  NR_INT  per-line enables (CP0 Status IM)
int_enable  in  1  global enable (IE & !EXL)
int_ack  out  NR_INT  one-hot ack, 1-cycle pulse
stall  out  1  pipeline stall
wb_valid  out  1  writeback strobe, 1-cycle pulse
wb_reg_addr  out  REG_ADDR_W  writeback register
wb_reg_data  out  32  writeback data
exc_valid  out  1  exception strobe, 1-cycle pulse
exc_code  out  EXC_W  exception code
exc_badvaddr  out  32  faulting address
exc_ip  out  NR_INT  interrupt one-hot for CP0 Cause
mmu_req  out  1  request, held until ack/fault/timeout
mmu_we  out  1  write
mmu_addr  out  32  word-aligned address (addr[1:0]=0)
mmu_be  out  4  byte enables
mmu_wdata  out  32  lane-replicated store data
mmu_rdata  in  32  read data, valid with mmu_ack
mmu_ack  in  1  transfer complete
mmu_exc_valid  in  1  MMU fault (TLB miss/mod)
mmu_exc_code  in  EXC_W  MMU fault code

Behaviour:
- Reset: state IDLE; every output 0; timeout counter 0. Async reset mid-transfer drops mmu_req immediately, no exception/writeback.
- All outputs registered. stall = (state==WAIT). Strobes (wb_valid, exc_valid, int_ack) last exactly one cycle; data/code fields hold until next strobe.
- IDLE, in_valid=1, priority high->low:
  1. in_exc_valid: exc pulse with in_exc_code/in_badvaddr; exc_ip=0.
  2. int_enable && (int_req&int_mask)!=0: exc_code=EC_INT, exc_ip=int_ack=one-hot of lowest-index pending line; instruction discarded.
  3. Misaligned (LH/LHU/SH addr[0]; LW/SW addr[1:0]!=0): EC_ADEL for loads, EC_ADES for stores, badvaddr=in_addr.
  4. op NONE: wb_valid pulse, wb_reg_addr=in_wb_addr, wb_reg_data=in_alu_result, next cycle.
  5. Memory op: latch op/addr/wb_addr, mmu_req=1, enter WAIT next cycle.
- IDLE, in_valid=0: interrupts still taken (rule 2), otherwise nothing.
- Byte lanes little-endian, k=addr[1:0]: SB be=1<<k, wdata={4{b}}; SH be=0011 (k=0) or 1100 (k=2), wdata={2{h}}; SW be=1111. Loads: be same pattern, mmu_we=0.
- WAIT (interrupts ignored; counter increments each cycle):
  - mmu_exc_valid: exc pulse with mmu_exc_code, badvaddr=latched addr; IDLE. Wins over simultaneous ack.
  - else mmu_ack: load -> wb pulse, data = selected lane, LB/LH sign-extended, LBU/LHU zero-extended; store -> no wb. IDLE. Ack wins over timeout in same cycle.
  - else counter==TIMEOUT (TIMEOUT!=0): exc EC_DBE, badvaddr=latched addr; IDLE.
  - mmu_req deasserted in the cycle IDLE resumes; counter cleared. New instruction may be accepted the cycle after return to IDLE.
- in_* ignored while stall=1 (upstream holds).

Test Plan:
- LB addr 0x1003, mmu_rdata 0x80FFFFFF, ack after 3 cycles -> be=1000, stall 3 cycles, wb_reg_data 0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x2002, wdata 0x1234ABCD -> mmu_addr 0x2000, be=1100, mmu_wdata 0xABCDABCD, no wb_valid.
- LW addr 0x3001 -> exc_valid, exc_code 4, badvaddr 0x3001, mmu_req stays 0.
- int_req=0b0110, mask=0xFF, enable=1 with op NONE -> exc_code 0, exc_ip=int_ack=0b0010 one cycle, no wb.
- TIMEOUT=4, LW with no ack -> exc_code 7 after 4 WAIT cycles, mmu_req drops; mmu_exc_valid and ack same cycle -> MMU code reported, no wb.
- rst asserted during WAIT -> mmu_req, stall 0 asynchronously; subsequent op NONE writes back normally.
